// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter.
// A one-cycle start request launches a fixed-latency conversion. The packed BCD
// result, the overflow flag and the leading-zero blanking mask are registered
// and held between conversions, so the display driver never sees partial values.
module binary_to_bcd_converter #(
  parameter int INPUT_WIDTH       = 16,
  parameter int NUMBER_OF_NYBBLES = 4
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [INPUT_WIDTH-1:0]         binary_in,
  output logic                           busy,
  output logic                           valid,
  output logic [4*NUMBER_OF_NYBBLES-1:0] bcd_out,
  output logic                           overflow,
  output logic [NUMBER_OF_NYBBLES-1:0]   blank
);

  localparam int BCD_WIDTH   = 4 * NUMBER_OF_NYBBLES;
  localparam int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1);

  localparam logic [COUNT_WIDTH-1:0]       COUNT_LOAD  = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0]       COUNT_LAST  = COUNT_WIDTH'(1);
  // Reset mask: every digit blanked except the units digit, so "0" is shown.
  localparam logic [NUMBER_OF_NYBBLES-1:0] BLANK_RESET = ~NUMBER_OF_NYBBLES'(1);

  // Saturated display value shown when the operand does not fit in the digits.
  function automatic logic [BCD_WIDTH-1:0] all_nines();
    logic [BCD_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NUMBER_OF_NYBBLES; i++) begin
      r[i*4 +: 4] = 4'd9;
    end
    return r;
  endfunction

  localparam logic [BCD_WIDTH-1:0] ALL_NINES = all_nines();

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_DONE
  } state_t;

  state_t                   state_q;
  state_t                   state_d;

  logic [INPUT_WIDTH-1:0]   operand_q;     // remaining binary bits, MSB first
  logic [BCD_WIDTH-1:0]     scratch_q;     // BCD digits built so far
  logic                     ovf_acc_q;     // sticky: a bit fell off the top digit
  logic [COUNT_WIDTH-1:0]   count_q;       // iterations still to perform

  logic                     load;
  logic                     iterate;
  logic                     finish;
  logic [BCD_WIDTH-1:0]     adjusted;
  logic [NUMBER_OF_NYBBLES-1:0] blank_d;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state datapath strobes.
  // NOTE: every signal written here gets a default first; a missing assignment
  // on some path would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    iterate = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        iterate = 1'b1;
        if (count_q == COUNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        finish  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Double-dabble correction: any digit of 5 or more gets 3 added so that the
  // following left shift carries correctly into the next decimal digit.
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < NUMBER_OF_NYBBLES; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) begin
        adjusted[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Leading-zero mask: digit i (i >= 1) is blanked when it and every higher digit
  // are zero. The units digit is never blanked; an overflowed result shows all 9s
  // and therefore nothing is blanked.
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    blank_d     = '0;
    for (int i = NUMBER_OF_NYBBLES - 1; i >= 1; i--) begin
      higher_zero = higher_zero & (scratch_q[i*4 +: 4] == 4'd0);
      blank_d[i]  = higher_zero;
    end
    if (ovf_acc_q) begin
      blank_d = '0;
    end
  end

  // Conversion datapath: load on acceptance, then one shift-and-adjust per cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      operand_q <= '0;
      scratch_q <= '0;
      ovf_acc_q <= 1'b0;
      count_q   <= '0;
    end else if (load) begin
      operand_q <= binary_in;
      scratch_q <= '0;
      ovf_acc_q <= 1'b0;
      count_q   <= COUNT_LOAD;
    end else if (iterate) begin
      scratch_q <= {adjusted[BCD_WIDTH-2:0], operand_q[INPUT_WIDTH-1]};
      operand_q <= {operand_q[INPUT_WIDTH-2:0], 1'b0};
      ovf_acc_q <= ovf_acc_q | adjusted[BCD_WIDTH-1];
      count_q   <= count_q - COUNT_LAST;
    end
  end

  // Result registers: updated only in DONE, held otherwise; valid pulses once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid    <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
      blank    <= BLANK_RESET;
    end else begin
      valid <= finish;
      if (finish) begin
        bcd_out  <= ovf_acc_q ? ALL_NINES : scratch_q;
        overflow <= ovf_acc_q;
        blank    <= blank_d;
      end
    end
  end

  // Busy covers CONVERT and DONE; it drops on the edge that raises valid.
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Directed self-checking bench for binary_to_bcd_converter (default parameters).
module tb_binary_to_bcd_converter;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [15:0] binary_in;
  logic        busy;
  logic        valid;
  logic [15:0] bcd_out;
  logic        overflow;
  logic [3:0]  blank;

  int checks   = 0;
  int failures = 0;

  binary_to_bcd_converter #(
    .INPUT_WIDTH       (16),
    .NUMBER_OF_NYBBLES (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .binary_in (binary_in),
    .busy      (busy),
    .valid     (valid),
    .bcd_out   (bcd_out),
    .overflow  (overflow),
    .blank     (blank)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge. Pulses start with the given operand and returns the
  // number of rising edges from the accepting edge to the first valid sample
  // (-1 on timeout), plus whether busy stayed high until then.
  task automatic run_conv(input logic [15:0] val, output int lat, output bit busy_ok);
    binary_in = val;
    start     = 1'b1;
    @(posedge clock);                 // edge 0
    @(negedge clock);
    start     = 1'b0;
    binary_in = 16'hBEEF;             // don't-care after acceptance
    busy_ok   = busy;
    lat       = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (valid) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  // Full conversion with result, latency and hold checks.
  task automatic do_case(input string name, input logic [15:0] val,
                         input logic [15:0] exp_bcd, input logic [3:0] exp_blank,
                         input logic exp_ovf);
    int lat;
    bit busy_ok;
    run_conv(val, lat, busy_ok);
    check({name, " latency"},  lat,      17);
    check({name, " busy"},     busy_ok,  1);
    check({name, " busy_low"}, busy,     0);
    check({name, " bcd"},      bcd_out,  exp_bcd);
    check({name, " blank"},    blank,    exp_blank);
    check({name, " ovf"},      overflow, exp_ovf);
    @(posedge clock);
    @(negedge clock);
    check({name, " valid_1cyc"}, valid,   0);
    check({name, " hold_bcd"},   bcd_out, exp_bcd);
  endtask

  initial begin
    int lat;
    int lat2;
    bit saw_valid;

    reset_n   = 1'b0;
    start     = 1'b0;
    binary_in = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state with no start.
    check("rst bcd",   bcd_out,  16'h0000);
    check("rst blank", blank,    4'b1110);
    check("rst busy",  busy,     0);
    check("rst valid", valid,    0);
    check("rst ovf",   overflow, 0);

    // Main function and range boundaries.
    do_case("d1234",  16'd1234,  16'h1234, 4'b0000, 1'b0);
    do_case("d0",     16'd0,     16'h0000, 4'b1110, 1'b0);
    do_case("d7",     16'd7,     16'h0007, 4'b1110, 1'b0);
    do_case("d42",    16'd42,    16'h0042, 4'b1100, 1'b0);
    do_case("d9999",  16'd9999,  16'h9999, 4'b0000, 1'b0);
    do_case("d10000", 16'd10000, 16'h9999, 4'b0000, 1'b1);
    do_case("d65535", 16'd65535, 16'h9999, 4'b0000, 1'b1);
    do_case("d5",     16'd5,     16'h0005, 4'b1110, 1'b0);

    // start held high, binary_in changing every cycle during a conversion of 321.
    binary_in = 16'd321;
    start     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      binary_in = 16'(1000 + k);
      @(posedge clock);
      @(negedge clock);
      if (valid) begin
        lat = k;
        break;
      end
    end
    check("b2b lat1",  lat,     17);
    check("b2b bcd1",  bcd_out, 16'h0321);
    check("b2b blank1", blank,  4'b1000);
    binary_in = 16'd777;              // present on the edge closing the valid cycle
    @(posedge clock);
    @(negedge clock);
    start     = 1'b0;
    binary_in = 16'd0;
    check("b2b busy2",  busy,  1);
    check("b2b valid2_low", valid, 0);
    lat2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (valid) begin
        lat2 = k + 1;
        break;
      end
    end
    check("b2b spacing", lat2,    18);
    check("b2b bcd2",    bcd_out, 16'h0777);
    @(posedge clock);
    @(negedge clock);

    // Leave overflow set so the reset check below observes real changes.
    do_case("pre_rst", 16'd65535, 16'h9999, 4'b0000, 1'b1);

    // Reset asserted after edge 8 of a conversion of 4321.
    binary_in = 16'd4321;
    start     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort bcd",   bcd_out,  16'h0000);
    check("abort blank", blank,    4'b1110);
    check("abort busy",  busy,     0);
    check("abort valid", valid,    0);
    check("abort ovf",   overflow, 0);
    saw_valid = 1'b0;
    repeat (2) begin
      @(negedge clock);
      if (valid) saw_valid = 1'b1;
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (valid) saw_valid = 1'b1;
    end
    check("abort no_valid", saw_valid, 0);

    // Fresh conversion after the abort.
    do_case("d55", 16'd55, 16'h0055, 4'b1100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/binary_to_bcd_converter.md
# binary_to_bcd_converter

Sequential double-dabble converter turning an unsigned binary count into packed BCD nybbles for the segmented display driver, so counters show decimal rather than hex. It sits directly upstream of the display driver: its `bcd_out` connects to the driver's `data` input and its `blank` output to the driver's digit-blanking logic. Each conversion is started by a one-cycle request and takes a fixed number of cycles. Between conversions the outputs stay registered and stable, so the multiplexed display never sees intermediate values.

## Interface
- `INPUT_WIDTH`, default 16: width of the binary operand.
- `NUMBER_OF_NYBBLES`, default 4: number of BCD digits produced. Digit 0 is least significant and occupies `bcd_out[3:0]`.
- `clock`  input  1: single clock; all state changes on its rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: conversion request, sampled only in IDLE.
- `binary_in`  input  INPUT_WIDTH: operand, captured on the accepting edge.
- `busy`  output  1: high while a conversion is in progress.
- `valid`  output  1: one-cycle pulse when new results are presented.
- `bcd_out`  output  4*NUMBER_OF_NYBBLES: packed BCD result, held until the next result.
- `overflow`  output  1: set when the operand exceeds 10^NUMBER_OF_NYBBLES−1; held with `bcd_out`.
- `blank`  output  NUMBER_OF_NYBBLES: per-digit leading-zero mask (1 = blank this digit); held with `bcd_out`.

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, `busy`=0, `valid`=0, `bcd_out`=0, `overflow`=0, `blank` = all ones except bit 0 (4'b1110 at default).
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - On `start`=1: load `binary_in` into the operand shift register, clear the BCD scratch register, clear the overflow accumulator, load the iteration counter with INPUT_WIDTH, go to CONVERT.
- CONVERT, one iteration per cycle:
  - Combinationally add 3 to every scratch digit ≥5.
  - Shift {scratch, operand} left by one.
  - The bit shifted out of the scratch MSB is ORed into the overflow accumulator.
  - Decrement the counter. After the INPUT_WIDTH-th iteration, go to DONE.
- DONE, single cycle:
  - If overflow was accumulated: register `bcd_out` as all 9s and `overflow`=1.
  - Otherwise: register `bcd_out` = scratch and `overflow`=0.
  - Register `blank`; assert `valid`; return to IDLE.
- `blank` rule: bit i=1 iff digit i and all higher digits are zero, for i≥1. Bit 0 is always 0. When overflow is set, `blank` is all zeros.
- `start` while `busy` is ignored; it is neither queued nor able to corrupt the conversion in progress.
- `binary_in` is don't-care except on the accepting edge.
- Every digit of `bcd_out` is always in 0–9.
- Counter width: clog2(INPUT_WIDTH+1) bits.

## Timing
- Let edge 0 be the rising edge on which `start` is sampled high in IDLE.
- `busy` is high from after edge 0 through the cycle before `valid`; it falls on the same edge that `valid` rises.
- Iterations occur on edges 1..INPUT_WIDTH. The DONE cycle lasts from edge INPUT_WIDTH to edge INPUT_WIDTH+1.
- `valid` is high during exactly one cycle: from edge INPUT_WIDTH+1 to edge INPUT_WIDTH+2. At default that is edge 17 to edge 18. `bcd_out`, `overflow` and `blank` change on edge INPUT_WIDTH+1 and on no other edge.
- Back-to-back: `start` sampled high during the `valid` cycle (FSM in IDLE) is accepted. Throughput is one conversion per INPUT_WIDTH+2 cycles.
- Reset mid-conversion: all outputs and state go to their reset values immediately on `reset_n` falling, with no clock edge needed.
  - No `valid` is produced for the aborted conversion.
  - `start` is accepted on the first rising edge after `reset_n` rises.

## Test plan
- After reset with no `start`:
  - Required: `bcd_out`=0x0000, `blank`=4'b1110, `busy`=0, `valid`=0, `overflow`=0.
- `binary_in`=1234, `start` pulsed at edge 0:
  - Required: `busy` high from after edge 0 until edge 17; `valid` pulses from edge 17 to edge 18; `bcd_out`=0x1234, `blank`=4'b0000, `overflow`=0. Outputs hold after the `valid` pulse.
- Operands 0, 7, 42, 9999:
  - Required `bcd_out`: 0x0000, 0x0007, 0x0042, 0x9999.
  - Required `blank`: 1110, 1110, 1100, 0000.
  - Required `overflow`=0 for all four.
- Operands 10000 and 65535:
  - Required for both: `bcd_out`=0x9999, `overflow`=1, `blank`=0000.
  - Then operand 5 is converted: required `overflow` clears to 0, `bcd_out`=0x0005.
- `start` held high with `binary_in` changing every cycle during a conversion of 321:
  - Required: result 0x0321. A second conversion begins only on the `valid` cycle, using the `binary_in` present on that edge; its `valid` follows exactly 18 edges after the first `valid`.
- `reset_n` asserted mid-conversion (edge 8 of a conversion of 4321):
  - Required: outputs immediately return to reset values; no `valid` pulse.
  - Then a fresh conversion of 55 is started: required `bcd_out`=0x0055 with normal latency.
